// File: rtl/gpio_axi_lite.sv
// AXI4-Lite GPIO controller: per-bit direction, synchronized input sampling,
// and edge/level interrupt events latched in a write-1-to-clear IRQ register.
module gpio_axi_lite #(
    parameter int          P_WIDTH   = 32,
    parameter logic [31:0] P_VERSION = 32'h2025_0910,
    parameter logic [31:0] P_NAME    = 32'h4750_494F
) (
    input  logic               axil_aclk,
    input  logic               axil_areset,
    input  logic [31:0]        s_axi_lite_awaddr,
    input  logic               s_axi_lite_awvalid,
    output logic               s_axi_lite_awready,
    input  logic [31:0]        s_axi_lite_wdata,
    input  logic               s_axi_lite_wvalid,
    output logic               s_axi_lite_wready,
    output logic [1:0]         s_axi_lite_bresp,
    output logic               s_axi_lite_bvalid,
    input  logic               s_axi_lite_bready,
    input  logic [31:0]        s_axi_lite_araddr,
    input  logic               s_axi_lite_arvalid,
    output logic               s_axi_lite_arready,
    output logic [31:0]        s_axi_lite_rdata,
    output logic [1:0]         s_axi_lite_rresp,
    output logic               s_axi_lite_rvalid,
    input  logic               s_axi_lite_rready,
    inout  wire  [P_WIDTH-1:0] GPIO,
    output logic               interrupt
);

    localparam logic [7:0] ADDR_VERSION = 8'h00;
    localparam logic [7:0] ADDR_NAME    = 8'h04;
    localparam logic [7:0] ADDR_DIR     = 8'h10;
    localparam logic [7:0] ADDR_INPUT   = 8'h14;
    localparam logic [7:0] ADDR_OUTPUT  = 8'h18;
    localparam logic [7:0] ADDR_MASK    = 8'h1C;
    localparam logic [7:0] ADDR_IRQ     = 8'h20;
    localparam logic [7:0] ADDR_EDGE    = 8'h24;
    localparam logic [7:0] ADDR_POL     = 8'h28;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [P_WIDTH-1:0] dir, out_q, mask, irq, edge_sel, pol;
    logic [P_WIDTH-1:0] sync1, sync2, prev;
    logic [P_WIDTH-1:0] rise, fall, evt, w1c;
    logic [31:0]        rd_value;
    logic               w_fire, r_fire;
    logic               unused_bits;

    // Misaligned offsets never match an entry, so they fall out as unmapped.
    function automatic logic addr_ok(input logic [7:0] a);
        case (a)
            ADDR_VERSION, ADDR_NAME, ADDR_DIR, ADDR_INPUT, ADDR_OUTPUT,
            ADDR_MASK, ADDR_IRQ, ADDR_EDGE, ADDR_POL: addr_ok = 1'b1;
            default:                                  addr_ok = 1'b0;
        endcase
    endfunction

    assign unused_bits = ^{s_axi_lite_awaddr[31:8], s_axi_lite_araddr[31:8], s_axi_lite_wdata};

    assign w_fire = s_axi_lite_awready && s_axi_lite_awvalid && s_axi_lite_wvalid;
    assign r_fire = s_axi_lite_arready && s_axi_lite_arvalid;

    assign s_axi_lite_wready = s_axi_lite_awready;
    assign s_axi_lite_bvalid = (w_state == W_RESP);
    assign s_axi_lite_rvalid = (r_state == R_DATA);

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (w_fire) w_next = W_RESP;
            W_RESP:  if (s_axi_lite_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (r_fire) r_next = R_DATA;
            R_DATA:  if (s_axi_lite_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Ready is registered and only raised once both address and data are present.
    always_ff @(posedge axil_aclk) begin
        if (axil_areset) begin
            w_state            <= W_IDLE;
            s_axi_lite_awready <= 1'b0;
            s_axi_lite_bresp   <= RESP_OKAY;
        end else begin
            w_state            <= w_next;
            s_axi_lite_awready <= (w_state == W_IDLE) && s_axi_lite_awvalid &&
                                  s_axi_lite_wvalid && !s_axi_lite_awready;
            if (w_fire)
                s_axi_lite_bresp <= addr_ok(s_axi_lite_awaddr[7:0]) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge axil_aclk) begin
        if (axil_areset) begin
            r_state            <= R_IDLE;
            s_axi_lite_arready <= 1'b0;
            s_axi_lite_rdata   <= '0;
            s_axi_lite_rresp   <= RESP_OKAY;
        end else begin
            r_state            <= r_next;
            s_axi_lite_arready <= (r_state == R_IDLE) && s_axi_lite_arvalid && !s_axi_lite_arready;
            if (r_fire) begin
                s_axi_lite_rdata <= rd_value;
                s_axi_lite_rresp <= addr_ok(s_axi_lite_araddr[7:0]) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_comb begin
        rd_value = '0;
        case (s_axi_lite_araddr[7:0])
            ADDR_VERSION: rd_value = P_VERSION;
            ADDR_NAME:    rd_value = P_NAME;
            ADDR_DIR:     rd_value[P_WIDTH-1:0] = dir;
            ADDR_INPUT:   rd_value[P_WIDTH-1:0] = sync2;
            ADDR_OUTPUT:  rd_value[P_WIDTH-1:0] = out_q;
            ADDR_MASK:    rd_value[P_WIDTH-1:0] = mask;
            ADDR_IRQ:     rd_value[P_WIDTH-1:0] = irq;
            ADDR_EDGE:    rd_value[P_WIDTH-1:0] = edge_sel;
            ADDR_POL:     rd_value[P_WIDTH-1:0] = pol;
            default:      rd_value = '0;
        endcase
    end

    always_ff @(posedge axil_aclk) begin
        if (axil_areset) begin
            dir      <= '0;
            out_q    <= '0;
            mask     <= '0;
            edge_sel <= '0;
            pol      <= '0;
        end else if (w_fire) begin
            case (s_axi_lite_awaddr[7:0])
                ADDR_DIR:    dir      <= s_axi_lite_wdata[P_WIDTH-1:0];
                ADDR_OUTPUT: out_q    <= s_axi_lite_wdata[P_WIDTH-1:0];
                ADDR_MASK:   mask     <= s_axi_lite_wdata[P_WIDTH-1:0];
                ADDR_EDGE:   edge_sel <= s_axi_lite_wdata[P_WIDTH-1:0];
                ADDR_POL:    pol      <= s_axi_lite_wdata[P_WIDTH-1:0];
                default:     ;
            endcase
        end
    end

    // Synchronizer keeps sampling through reset so no spurious edge fires on release.
    always_ff @(posedge axil_aclk) begin
        sync1 <= GPIO;
        sync2 <= sync1;
        prev  <= sync2;
    end

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;
    assign evt  = (edge_sel & pol & rise) | (edge_sel & ~pol & fall) |
                  (~edge_sel & pol & sync2) | (~edge_sel & ~pol & ~sync2);

    always_comb begin
        w1c = '0;
        if (w_fire && s_axi_lite_awaddr[7:0] == ADDR_IRQ)
            w1c = s_axi_lite_wdata[P_WIDTH-1:0];
    end

    // A new event in the same cycle as a clear keeps the bit set.
    always_ff @(posedge axil_aclk) begin
        if (axil_areset) begin
            irq       <= '0;
            interrupt <= 1'b0;
        end else begin
            irq       <= evt | (irq & ~w1c);
            interrupt <= |(irq & mask);
        end
    end

    for (genvar i = 0; i < P_WIDTH; i++) begin : g_pin
        assign GPIO[i] = dir[i] ? out_q[i] : 1'bz;
    end

endmodule

// File: tb/tb_gpio_axi_lite.sv
// Directed self-checking bench for gpio_axi_lite; the bench acts as the external
// pin driver on every bit it has not configured as a DUT output.
module tb_gpio_axi_lite;

    localparam logic [31:0] VERSION = 32'h2025_0910;
    localparam logic [31:0] NAME    = 32'h4750_494F;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid, interrupt;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    wire  [31:0] gpio;
    logic [31:0] ext_val = '1;
    logic [31:0] ext_en  = '1;

    int checks   = 0;
    int failures = 0;

    gpio_axi_lite dut (
        .axil_aclk          (clk),
        .axil_areset        (rst),
        .s_axi_lite_awaddr  (awaddr),
        .s_axi_lite_awvalid (awvalid),
        .s_axi_lite_awready (awready),
        .s_axi_lite_wdata   (wdata),
        .s_axi_lite_wvalid  (wvalid),
        .s_axi_lite_wready  (wready),
        .s_axi_lite_bresp   (bresp),
        .s_axi_lite_bvalid  (bvalid),
        .s_axi_lite_bready  (bready),
        .s_axi_lite_araddr  (araddr),
        .s_axi_lite_arvalid (arvalid),
        .s_axi_lite_arready (arready),
        .s_axi_lite_rdata   (rdata),
        .s_axi_lite_rresp   (rresp),
        .s_axi_lite_rvalid  (rvalid),
        .s_axi_lite_rready  (rready),
        .GPIO               (gpio),
        .interrupt          (interrupt)
    );

    for (genvar i = 0; i < 32; i++) begin : g_ext
        assign gpio[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog sim_time=%0t limit=2000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Bus drivers: called just after a negedge, return just after a negedge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int n;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (!awready) begin
            checks++; failures++;
            $display("[TB] FAIL write_accept addr=%h awready=%b required=1", addr, awready);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (!bvalid) begin
            checks++; failures++;
            $display("[TB] FAIL write_resp addr=%h bvalid=%b required=1", addr, bvalid);
        end
        resp = bresp;
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (!arready) begin
            checks++; failures++;
            $display("[TB] FAIL read_accept addr=%h arready=%b required=1", addr, arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (!rvalid) begin
            checks++; failures++;
            $display("[TB] FAIL read_resp addr=%h rvalid=%b required=1", addr, rvalid);
        end
        data = rdata;
        resp = rresp;
        @(negedge clk);
    endtask

    // Pins are held high by the bench, so INPUT reads all ones and no level-low
    // event can latch into IRQ after reset.
    task automatic test_reset();
        logic [31:0] addrs [9] = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28};
        logic [31:0] exps  [9] = '{VERSION, NAME, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [41:0] outs;
        logic [31:0] d;
        logic [1:0]  r;
        @(negedge clk); rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        outs = {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, interrupt};
        checks++;
        if (outs !== 42'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h required=0", outs);
        end
        for (int i = 0; i < 9; i++) begin
            axi_read(addrs[i], d, r);
            checks++;
            if (d !== exps[i] || r !== OKAY) begin
                failures++;
                $display("[TB] FAIL reset_csr addr=%h got=%h/%b required=%h/%b", addrs[i], d, r, exps[i], OKAY);
            end
        end
    endtask

    task automatic test_gpio_output();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h18, 32'h0000_A5A5, r);
        ext_en = 32'hFFFF_0000;
        axi_write(32'h10, 32'h0000_FFFF, r);
        repeat (4) @(negedge clk);
        axi_read(32'h14, d, r);
        checks++;
        if (d !== 32'hFFFF_A5A5) begin
            failures++;
            $display("[TB] FAIL input_readback got=%h required=FFFFA5A5", d);
        end
        // The read below samples sync2 two edges after the pin change: still the old value.
        ext_val = 32'h1234_0000;
        axi_read(32'h14, d, r);
        checks++;
        if (d !== 32'hFFFF_A5A5) begin
            failures++;
            $display("[TB] FAIL input_sync_latency got=%h required=FFFFA5A5", d);
        end
        checks++;
        if (gpio !== 32'h1234_A5A5) begin
            failures++;
            $display("[TB] FAIL gpio_pins got=%h required=1234A5A5", gpio);
        end
        repeat (3) @(negedge clk);
        axi_read(32'h14, d, r);
        checks++;
        if (d !== 32'h1234_A5A5) begin
            failures++;
            $display("[TB] FAIL input_new got=%h required=1234A5A5", d);
        end
        axi_write(32'h10, 32'h0, r);
        ext_en = '1; ext_val = '1;
        repeat (4) @(negedge clk);
        axi_write(32'h20, 32'hFFFF_FFFF, r);
        axi_read(32'h20, d, r);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL irq_clear_all got=%h required=0", d);
        end
    endtask

    task automatic test_concurrent();
        logic [31:0] d;
        logic [1:0]  wr, rr;
        fork
            axi_write(32'h18, 32'h0000_00FF, wr);
            axi_read(32'h04, d, rr);
        join
        checks++;
        if (d !== NAME || rr !== OKAY || wr !== OKAY) begin
            failures++;
            $display("[TB] FAIL concurrent got=%h/%b/%b required=%h/00/00", d, rr, wr, NAME);
        end
        axi_read(32'h18, d, rr);
        checks++;
        if (d !== 32'h0000_00FF) begin
            failures++;
            $display("[TB] FAIL concurrent_write got=%h required=000000FF", d);
        end
    endtask

    task automatic test_edge_irq();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h24, 32'h1, r);
        axi_write(32'h28, 32'h1, r);
        axi_write(32'h1C, 32'h1, r);
        ext_val[0] = 1'b0;
        repeat (5) @(negedge clk);
        axi_read(32'h20, d, r);
        checks++;
        if (d !== 32'h0 || interrupt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL edge_falling_ignored got=%h/%b required=0/0", d, interrupt);
        end
        ext_val[0] = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (interrupt !== 1'b1) begin
            failures++;
            $display("[TB] FAIL edge_interrupt got=%b required=1", interrupt);
        end
        axi_read(32'h20, d, r);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("[TB] FAIL edge_irq got=%h required=1", d);
        end
        axi_write(32'h20, 32'h1, r);
        axi_read(32'h20, d, r);
        checks++;
        if (d !== 32'h0 || interrupt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL edge_w1c got=%h/%b required=0/0", d, interrupt);
        end
        ext_val[0] = 1'b0;
        repeat (5) @(negedge clk);
        axi_read(32'h20, d, r);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL edge_fall_after_clear got=%h required=0", d);
        end
    endtask

    task automatic test_level_irq();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h1C, 32'h3, r);
        ext_val[1] = 1'b0;
        repeat (4) @(negedge clk);
        axi_read(32'h20, d, r);
        checks++;
        if (d !== 32'h2 || interrupt !== 1'b1) begin
            failures++;
            $display("[TB] FAIL level_set got=%h/%b required=2/1", d, interrupt);
        end
        axi_write(32'h20, 32'h2, r);
        axi_read(32'h20, d, r);
        checks++;
        if (d !== 32'h2 || interrupt !== 1'b1) begin
            failures++;
            $display("[TB] FAIL level_reassert got=%h/%b required=2/1", d, interrupt);
        end
        axi_write(32'h1C, 32'h1, r);
        checks++;
        if (interrupt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mask_gates_output got=%b required=0", interrupt);
        end
        axi_read(32'h20, d, r);
        checks++;
        if (d !== 32'h2) begin
            failures++;
            $display("[TB] FAIL irq_ignores_mask got=%h required=2", d);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(32'h0C, d, r);
        checks++;
        if (d !== 32'h0 || r !== SLVERR) begin
            failures++;
            $display("[TB] FAIL read_unmapped got=%h/%b required=0/10", d, r);
        end
        axi_read(32'h11, d, r);
        checks++;
        if (d !== 32'h0 || r !== SLVERR) begin
            failures++;
            $display("[TB] FAIL read_misaligned got=%h/%b required=0/10", d, r);
        end
        axi_write(32'h30, 32'hFFFF_FFFF, r);
        checks++;
        if (r !== SLVERR) begin
            failures++;
            $display("[TB] FAIL write_unmapped got=%b required=10", r);
        end
        axi_write(32'h12, 32'h0000_FFFF, r);
        checks++;
        if (r !== SLVERR) begin
            failures++;
            $display("[TB] FAIL write_misaligned got=%b required=10", r);
        end
        axi_read(32'h10, d, r);
        checks++;
        if (d !== 32'h0 || r !== OKAY) begin
            failures++;
            $display("[TB] FAIL dir_untouched got=%h/%b required=0/00", d, r);
        end
        axi_write(32'h00, 32'h0, r);
        checks++;
        if (r !== OKAY) begin
            failures++;
            $display("[TB] FAIL write_ro_resp got=%b required=00", r);
        end
        axi_read(32'h00, d, r);
        checks++;
        if (d !== VERSION) begin
            failures++;
            $display("[TB] FAIL version_untouched got=%h required=%h", d, VERSION);
        end
    endtask

    task automatic test_aw_alone();
        logic [31:0] d;
        logic [1:0]  r;
        logic        seen;
        int          n;
        awaddr = 32'h24; wdata = 32'h5; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | awready | wready;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL aw_alone_ready got=%b required=0", seen);
        end
        wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!awready) begin
            failures++;
            $display("[TB] FAIL aw_then_w_accept awready=%b required=1", awready);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        axi_read(32'h24, d, r);
        checks++;
        if (d !== 32'h5) begin
            failures++;
            $display("[TB] FAIL aw_then_w_data got=%h required=5", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        logic        bad;
        int          n;
        awaddr = 32'h18; wdata = 32'h11; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        wdata = 32'h22;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bvalid !== 1'b1 || awready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad !== 1'b0 || bresp !== OKAY) begin
            failures++;
            $display("[TB] FAIL bready_hold bad=%b bresp=%b required=0/00", bad, bresp);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bvalid_drop got=%b required=0", bvalid);
        end
        axi_read(32'h18, d, r);
        checks++;
        if (d !== 32'h11) begin
            failures++;
            $display("[TB] FAIL second_write_blocked got=%h required=11", d);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        logic [1:0]  r;
        int          n;
        araddr = 32'h00; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== VERSION) begin
            failures++;
            $display("[TB] FAIL rdata_hold got=%b/%h required=1/%h", rvalid, rdata, VERSION);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_abort_read got=%b/%h required=0/0", rvalid, rdata);
        end
        rst = 1'b0;
        axi_read(32'h18, d, r);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_output_reg got=%h required=0", d);
        end
    endtask

    initial begin
        test_reset();
        test_gpio_output();
        test_concurrent();
        test_edge_irq();
        test_level_irq();
        test_errors();
        test_aw_alone();
        test_back_to_back();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
